// File: rtl/dds_tune_ctrl.sv
`timescale 1ns/1ps
// dds_tune_ctrl: tuning sequencer in front of the DDS (NCO + reconfigurable PLL).
// Applies the NCO word first, then (if M changes) reprograms the PLL and waits
// for a stable lock. Build option DDS_TUNE_RETRY_EN adds pll_reset lock retries.
module dds_tune_ctrl #(
  parameter int unsigned INIT_M      = 104,
  parameter int unsigned BUSY_TO     = 64,
  parameter int unsigned LOCK_TO     = 4096,
  parameter int unsigned LOCK_STABLE = 16
`ifdef DDS_TUNE_RETRY_EN
  ,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned RST_CYCLES  = 8
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tune_valid,
  output logic        tune_ready,
  input  logic [8:0]  tune_m,
  input  logic [31:0] tune_f,
  output logic [8:0]  counter_data,
  output logic [31:0] nco_f,
  output logic        update,
  output logic        pll_reset,
  input  logic        busy,
  input  logic        locked,
  output logic        tuned,
  output logic        err
);

  localparam int unsigned M_W     = 9;
  localparam int unsigned F_W     = 32;
  localparam int unsigned TMO_MAX = (BUSY_TO > LOCK_TO) ? BUSY_TO : LOCK_TO;
  localparam int unsigned CNT_W   = $clog2(TMO_MAX) + 1;

  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TO - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TO - 1);
  localparam logic [CNT_W-1:0] STAB_TGT  = CNT_W'(LOCK_STABLE);
`ifdef DDS_TUNE_RETRY_EN
  localparam int unsigned      RTY_W     = $clog2(MAX_RETRY + 2);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT_BUSY,
    S_WAIT_IDLE,
    S_WAIT_LOCK,
    S_SETTLE,
    S_DONE,
    S_ERROR,
    S_RETRY
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [CNT_W-1:0] stab_q, stab_d, stab_inc;
  logic [M_W-1:0]   m_q, m_d;
  logic [M_W-1:0]   cur_m_q, cur_m_d;
  logic             m_valid_q, m_valid_d;
  logic [M_W-1:0]   counter_data_q, counter_data_d;
  logic [F_W-1:0]   nco_f_q, nco_f_d;
  logic             update_q, update_d;
  logic             ready_q, ready_d;
  logic             tuned_q, tuned_d;
  logic             err_q, err_d;
`ifdef DDS_TUNE_RETRY_EN
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             pll_reset_q, pll_reset_d;
`endif

  // Saturating increments: counters stop at their ceiling instead of wrapping
  assign tmo_inc  = (tmo_q == '1) ? tmo_q : tmo_q + CNT_W'(1);
  assign stab_inc = !locked ? '0 : ((stab_q == STAB_TGT) ? stab_q : stab_q + CNT_W'(1));

  // Next-state and registered-output decode
  always_comb begin
    state_d        = state_q;
    tmo_d          = tmo_inc;
    stab_d         = '0;
    m_d            = m_q;
    cur_m_d        = cur_m_q;
    m_valid_d      = m_valid_q;
    counter_data_d = counter_data_q;
    nco_f_d        = nco_f_q;
    tuned_d        = tuned_q;
    err_d          = err_q;
`ifdef DDS_TUNE_RETRY_EN
    retry_d        = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tune_valid && ready_q) begin
          m_d     = tune_m;
          nco_f_d = tune_f;
          tuned_d = 1'b0;
          err_d   = 1'b0;
`ifdef DDS_TUNE_RETRY_EN
          retry_d = '0;
`endif
          state_d = (m_valid_q && (tune_m == cur_m_q)) ? S_SETTLE : S_LOAD;
        end else if (tuned_q && !locked) begin
          tuned_d = 1'b0;
        end
      end
      S_LOAD: begin
        counter_data_d = m_q;
        state_d        = S_REQ;
      end
      S_REQ: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (busy)                    state_d = S_WAIT_IDLE;
        else if (tmo_q == BUSY_LAST) state_d = S_ERROR;
      end
      S_WAIT_IDLE: begin
        if (!busy)                   state_d = S_WAIT_LOCK;
        else if (tmo_q == BUSY_LAST) state_d = S_ERROR;
      end
      S_WAIT_LOCK: begin
        stab_d = stab_inc;
        if (stab_q == STAB_TGT) begin
          state_d = S_DONE;
        end else if (tmo_q == LOCK_LAST) begin
`ifdef DDS_TUNE_RETRY_EN
          state_d = (retry_q < RTY_W'(MAX_RETRY)) ? S_RETRY : S_ERROR;
`else
          state_d = S_ERROR;
`endif
        end
      end
      S_SETTLE: begin
        stab_d = stab_inc;
        if (stab_q == STAB_TGT)      state_d = S_DONE;
        else if (tmo_q == LOCK_LAST) state_d = S_ERROR;
      end
      S_DONE: begin
        cur_m_d   = m_q;
        m_valid_d = 1'b1;
        tuned_d   = 1'b1;
        state_d   = S_IDLE;
      end
      S_ERROR: begin
        err_d     = 1'b1;
        m_valid_d = 1'b0;
        tuned_d   = 1'b0;
        state_d   = S_IDLE;
      end
`ifdef DDS_TUNE_RETRY_EN
      S_RETRY: begin
        if (tmo_q == RST_LAST) begin
          retry_d = retry_q + RTY_W'(1);
          state_d = S_WAIT_LOCK;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Every state entry starts with fresh timeout and stability counts
    if (state_d != state_q) begin
      tmo_d  = '0;
      stab_d = '0;
    end

    update_d = (state_d == S_REQ);
    ready_d  = (state_d == S_IDLE);
`ifdef DDS_TUNE_RETRY_EN
    pll_reset_d = (state_d == S_RETRY);
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      tmo_q          <= '0;
      stab_q         <= '0;
      m_q            <= M_W'(INIT_M);
      cur_m_q        <= M_W'(INIT_M);
      m_valid_q      <= 1'b1;
      counter_data_q <= M_W'(INIT_M);
      nco_f_q        <= '0;
      update_q       <= 1'b0;
      ready_q        <= 1'b1;
      tuned_q        <= 1'b0;
      err_q          <= 1'b0;
`ifdef DDS_TUNE_RETRY_EN
      retry_q        <= '0;
      pll_reset_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      tmo_q          <= tmo_d;
      stab_q         <= stab_d;
      m_q            <= m_d;
      cur_m_q        <= cur_m_d;
      m_valid_q      <= m_valid_d;
      counter_data_q <= counter_data_d;
      nco_f_q        <= nco_f_d;
      update_q       <= update_d;
      ready_q        <= ready_d;
      tuned_q        <= tuned_d;
      err_q          <= err_d;
`ifdef DDS_TUNE_RETRY_EN
      retry_q        <= retry_d;
      pll_reset_q    <= pll_reset_d;
`endif
    end
  end

  assign tune_ready   = ready_q;
  assign counter_data = counter_data_q;
  assign nco_f        = nco_f_q;
  assign update       = update_q;
  assign tuned        = tuned_q;
  assign err          = err_q;
`ifdef DDS_TUNE_RETRY_EN
  assign pll_reset    = pll_reset_q;
`else
  assign pll_reset    = 1'b0;
`endif

endmodule

// File: tb/tb_dds_tune_ctrl.sv
`timescale 1ns/1ps
// Bench for dds_tune_ctrl: DDS behavioural model, request-level reference model,
// directed scenarios and a randomized request loop.
module tb_dds_tune_ctrl;

  localparam int unsigned INIT_M      = 104;
  localparam int unsigned BUSY_TO     = 64;
  localparam int unsigned LOCK_TO     = 4096;
  localparam int unsigned LOCK_STABLE = 16;
`ifdef DDS_TUNE_RETRY_EN
  localparam int unsigned MAX_RETRY   = 2;
  localparam int unsigned RST_CYCLES  = 8;
  localparam int unsigned LOCK_BOUND  = (MAX_RETRY + 1) * (LOCK_TO + RST_CYCLES + 8) + 300;
`else
  localparam int unsigned LOCK_BOUND  = LOCK_TO + 300;
`endif

  localparam int M_NORMAL = 0;
  localparam int M_NOBUSY = 1;
  localparam int M_TOGGLE = 2;
  localparam int M_NOLOCK = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tune_valid = 1'b0;
  logic [8:0]  tune_m = '0;
  logic [31:0] tune_f = '0;
  logic        tune_ready, update, pll_reset, tuned, err;
  logic [8:0]  counter_data;
  logic [31:0] nco_f;
  logic        busy = 1'b0;
  logic        lk_mdl = 1'b1;
  logic        lk_drop = 1'b0;
  logic        locked;
  int          mode = M_NORMAL;

  assign locked = lk_mdl & ~lk_drop;

  dds_tune_ctrl #(
    .INIT_M      (INIT_M),
    .BUSY_TO     (BUSY_TO),
    .LOCK_TO     (LOCK_TO),
    .LOCK_STABLE (LOCK_STABLE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tune_valid   (tune_valid),
    .tune_ready   (tune_ready),
    .tune_m       (tune_m),
    .tune_f       (tune_f),
    .counter_data (counter_data),
    .nco_f        (nco_f),
    .update       (update),
    .pll_reset    (pll_reset),
    .busy         (busy),
    .locked       (locked),
    .tuned        (tuned),
    .err          (err)
  );

  always #5 clk = ~clk;

  // DDS model: on update, drop lock, raise busy after 3 cycles for 20, then lock per mode
  initial begin : dds_model
    forever begin
      @(posedge clk); #1;
      if (update === 1'b1 && mode != M_NOBUSY) begin
        lk_mdl = 1'b0;
        repeat (3) @(negedge clk);
        busy = 1'b1;
        repeat (20) @(negedge clk);
        busy = 1'b0;
        if (mode == M_NORMAL) begin
          repeat (5) @(negedge clk);
          lk_mdl = 1'b1;
        end else if (mode == M_TOGGLE) begin
          while (mode == M_TOGGLE) begin
            for (int i = 0; i < 8 && mode == M_TOGGLE; i++) @(negedge clk);
            lk_mdl = ~lk_mdl;
          end
          lk_mdl = 1'b1;
        end
      end
    end
  end

  // Pulse monitors for update and pll_reset
  int upd_cnt = 0, upd_run = 0, upd_max = 0;
  int pr_run = 0, pr_pulses = 0, pr_wmin = 0, pr_wmax = 0;
  always @(negedge clk) begin
    if (update === 1'b1) begin
      upd_cnt++;
      upd_run++;
      if (upd_run > upd_max) upd_max = upd_run;
    end else begin
      upd_run = 0;
    end
    if (pll_reset === 1'b1) begin
      pr_run++;
    end else if (pr_run != 0) begin
      pr_pulses++;
      if (pr_wmin == 0 || pr_run < pr_wmin) pr_wmin = pr_run;
      if (pr_run > pr_wmax) pr_wmax = pr_run;
      pr_run = 0;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Request-level reference model
  logic [8:0] ref_cur_m = 9'(INIT_M);
  bit         ref_m_valid = 1'b1;
  logic [8:0] ref_cd = 9'(INIT_M);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request in IDLE; returns just after the accepting edge
  task automatic send(input logic [8:0] m, input logic [31:0] f);
    int n = 0;
    @(negedge clk);
    while (tune_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", 64'(tune_ready), 64'd1);
    tune_m     = m;
    tune_f     = f;
    tune_valid = 1'b1;
    @(posedge clk); #1;
    tune_valid = 1'b0;
    tune_m     = $urandom_range(0, 511);
    tune_f     = $urandom;
  endtask

  // Wait for tuned or err; cyc counts clock edges after the accepting edge
  task automatic wait_end(input int bound, output int cyc);
    cyc = 0;
    while (tuned !== 1'b1 && err !== 1'b1 && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Request expected to complete successfully
  task automatic run_ok(input string tag, input logic [8:0] m, input logic [31:0] f);
    bit reconf;
    int base, cyc;
    reconf = !(ref_m_valid && (m == ref_cur_m));
    base   = upd_cnt;
    send(m, f);
    check({tag, "_nco_f"}, 64'(nco_f), 64'(f));
    check({tag, "_ready_low"}, 64'(tune_ready), 64'd0);
    wait_end(400, cyc);
    check({tag, "_tuned"}, 64'(tuned), 64'd1);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_updates"}, 64'(upd_cnt - base), 64'(reconf ? 1 : 0));
    if (reconf) ref_cd = m;
    check({tag, "_counter_data"}, 64'(counter_data), 64'(ref_cd));
    if (!reconf) check({tag, "_nco_only_latency"}, 64'(cyc), 64'(LOCK_STABLE + 2));
    ref_cur_m   = m;
    ref_m_valid = 1'b1;
  endtask

  // Request expected to end in a timeout error
  task automatic run_err(input string tag, input logic [8:0] m, input logic [31:0] f,
                         input int md, input int bound, input int min_cyc, input int max_cyc);
    int base, cyc;
    mode = md;
    base = upd_cnt;
    send(m, f);
    check({tag, "_nco_f"}, 64'(nco_f), 64'(f));
    wait_end(bound, cyc);
    check({tag, "_err"}, 64'(err), 64'd1);
    check({tag, "_tuned"}, 64'(tuned), 64'd0);
    check({tag, "_updates"}, 64'(upd_cnt - base), 64'd1);
    check({tag, "_counter_data"}, 64'(counter_data), 64'(m));
    check({tag, "_latency_window"}, 64'((cyc >= min_cyc) && (cyc <= max_cyc)), 64'd1);
    ref_cd      = m;
    ref_m_valid = 1'b0;
    mode = M_NORMAL;
    repeat (10) @(negedge clk);
  endtask

  initial begin : stimulus
    int cyc;
    int pr_base;
    logic [8:0] m;

    // Reset values
    #3 reset = 1'b0;
    #10;
    check("rst_ready", 64'(tune_ready), 64'd1);
    check("rst_counter_data", 64'(counter_data), 64'(INIT_M));
    check("rst_nco_f", 64'(nco_f), 64'd0);
    check("rst_update", 64'(update), 64'd0);
    check("rst_pll_reset", 64'(pll_reset), 64'd0);
    check("rst_tuned", 64'(tuned), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reconfigure to M=120, then NCO-only retune at the same M
    run_ok("t1", 9'd120, 32'h1000_0000);
    run_ok("t2", 9'd120, 32'h2000_0000);

    // busy never rises: timeout after BUSY_TO cycles in WAIT_BUSY
    run_err("t3", 9'd90, 32'h0300_0000, M_NOBUSY, 400, BUSY_TO + 2, BUSY_TO + 4);
    // After an error the same-M request must still reprogram the PLL
    run_ok("t3b", 9'd120, 32'h0400_0000);

    // locked chatters every 8 cycles: never stable, so lock timeout
    run_err("t4", 9'd100, 32'h0500_0000, M_TOGGLE, LOCK_BOUND, LOCK_TO, LOCK_BOUND);

`ifdef DDS_TUNE_RETRY_EN
    // locked never asserts: MAX_RETRY pll_reset pulses before the error
    pr_base = pr_pulses;
    run_err("t5", 9'd77, 32'h0600_0000, M_NOLOCK, LOCK_BOUND, (MAX_RETRY + 1) * LOCK_TO, LOCK_BOUND);
    check("t5_pll_reset_pulses", 64'(pr_pulses - pr_base), 64'(MAX_RETRY));
    check("t5_pll_reset_wmin", 64'(pr_wmin), 64'(RST_CYCLES));
    check("t5_pll_reset_wmax", 64'(pr_wmax), 64'(RST_CYCLES));
`else
    pr_base = pr_pulses;
    check("pll_reset_idle", 64'(pll_reset), 64'd0);
`endif

    // Randomized requests, mixing same-M retunes and new M values
    for (int i = 0; i < 10; i++) begin
      if (ref_m_valid && $urandom_range(0, 1) == 1) m = ref_cur_m;
      else m = 9'($urandom_range(0, 511));
      run_ok($sformatf("rnd%0d", i), m, $urandom);
    end

    // Loss of lock in IDLE clears tuned on the next edge, leaves err alone
    check("drop_pre_tuned", 64'(tuned), 64'd1);
    @(negedge clk);
    lk_drop = 1'b1;
    @(posedge clk); #1;
    check("drop_tuned", 64'(tuned), 64'd0);
    check("drop_err", 64'(err), 64'd0);
    @(negedge clk);
    lk_drop = 1'b0;

    // Asynchronous reset while waiting for busy to fall
    send(9'd200, 32'hDEAD_BEEF);
    cyc = 0;
    while (busy !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_busy_seen", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    check("mid_counter_data", 64'(counter_data), 64'd200);
    check("mid_ready", 64'(tune_ready), 64'd0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_counter_data", 64'(counter_data), 64'(INIT_M));
    check("mid_rst_nco_f", 64'(nco_f), 64'd0);
    check("mid_rst_update", 64'(update), 64'd0);
    check("mid_rst_pll_reset", 64'(pll_reset), 64'd0);
    check("mid_rst_tuned", 64'(tuned), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_ready", 64'(tune_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(tune_ready), 64'd1);
    check("post_rst_counter_data", 64'(counter_data), 64'(INIT_M));

    // Global pulse properties
    check("update_single_cycle", 64'(upd_max), 64'd1);
`ifndef DDS_TUNE_RETRY_EN
    check("pll_reset_never", 64'(pr_pulses - pr_base + pr_run), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_tune_ctrl.md
Name: dds_tune_ctrl

Overview:
Tuning sequencer directly upstream of the DDS (NCO + reconfigurable PLL) block. Accepts a tuning request (PLL M-counter value plus 32-bit NCO frequency word) over a valid/ready handshake. Drives the DDS inputs counter_data, nco_f, update and pll_reset, and sequences the PLL reconfiguration against the DDS busy/locked outputs. Reports completion, or timeout error, to the host/control logic.

Parameters:
INIT_M, 104, M value the PLL powers up with; reset value of counter_data.
BUSY_TO, 64, max clk cycles to wait for busy to rise after update, and separately for it to fall.
LOCK_TO, 4096, max clk cycles to wait for lock after reconfig completes.
LOCK_STABLE, 16, consecutive cycles locked must be high to declare tuned.
MAX_RETRY, 2, lock retries (used only with the optional feature).
RST_CYCLES, 8, pll_reset pulse width in cycles (optional feature only).

Ports:
clk  input  1  system clock; same clock as the DDS reconfig logic.
reset  input  1  asynchronous, active-low reset.
tune_valid  input  1  request valid.
tune_ready  output  1  high only in IDLE.
tune_m  input  9  requested PLL M count.
tune_f  input  32  requested NCO frequency word.
counter_data  output  9  to DDS counter_data.
nco_f  output  32  to DDS nco_f.
update  output  1  to DDS update; single-cycle pulse.
pll_reset  output  1  to DDS pll_reset.
busy  input  1  from DDS busy.
locked  input  1  from DDS locked.
tuned  output  1  last request completed and PLL locked.
err  output  1  sticky timeout error.

Behaviour:
- Reset (reset=0, async): state IDLE; counter_data=INIT_M; nco_f=0; update=0; pll_reset=0; tuned=0; err=0; cur_m=INIT_M; m_valid=1; all counters cleared.
- The handshake completes on a clk edge where tune_valid && tune_ready. tune_valid is ignored while tune_ready=0; requests are never queued.
- On accept: latch tune_m and tune_f. nco_f takes tune_f on that same edge, so it is visible the next cycle. tuned and err clear on that edge.
- NCO-only path: if tune_m==cur_m and m_valid=1, go to SETTLE. No update is issued.
- Otherwise go to LOAD. The PLL is reprogrammed after nco_f is applied, so the NCO is never stale.
- LOAD: counter_data<=latched m (one cycle) -> REQ.
- REQ: update=1 for exactly one cycle -> WAIT_BUSY.
- WAIT_BUSY: on busy=1 -> WAIT_IDLE. If BUSY_TO cycles elapse -> ERROR.
- WAIT_IDLE: on busy=0 -> WAIT_LOCK. If BUSY_TO cycles elapse -> ERROR.
- WAIT_LOCK: a stability counter increments while locked=1 and resets to 0 when locked=0. When it reaches LOCK_STABLE -> DONE. If LOCK_TO cycles elapse first -> ERROR (or RETRY, see optional feature).
- SETTLE (NCO-only path): requires locked=1 for LOCK_STABLE cycles under the same timeout rules, then DONE.
- DONE: cur_m<=m; m_valid<=1; tuned<=1 -> IDLE. Minimum accept-to-tuned latency is LOCK_STABLE+2 cycles on the NCO-only path.
- ERROR: err<=1; m_valid<=0, forcing the next request to reconfigure regardless of M; tuned=0 -> IDLE.
- In IDLE with tuned=1: if locked falls, tuned clears the next cycle. err is unaffected.
- All timeout counters reset on every state entry. Counter width is clog2 of the largest timeout +1. Counters never wrap.
- Asynchronous reset mid-sequence returns to the reset values immediately. The DDS is responsible for abandoning any in-flight scan.

Optional Feature:
DDS_TUNE_RETRY_EN
- Defined: a WAIT_LOCK timeout enters RETRY while the retry count is below MAX_RETRY. RETRY asserts pll_reset for RST_CYCLES cycles, increments the retry count, then goes to WAIT_LOCK with fresh counters. Once retries are exhausted -> ERROR. The retry count clears on accept.
- Undefined: a WAIT_LOCK timeout goes directly to ERROR. pll_reset is tied to 0 and the retry count is absent.

Test Plan:
- Reset, then request m=120, f=0x1000_0000; DDS model: busy high at +3 cycles for 20 cycles, then locked at +5 -> one update pulse; counter_data=120; nco_f=0x10000000 one cycle after accept; tuned=1; err=0.
- After the above, request m=120, f=0x2000_0000 with locked steady -> no update pulse; tuned=1 exactly LOCK_STABLE+2 cycles after accept.
- Request m=90 with busy never rising -> err=1 after BUSY_TO cycles in WAIT_BUSY; tuned=0. The next request with m=120 still issues an update (m_valid=0).
- Request m=100 with locked toggling every 8 cycles (LOCK_STABLE=16) -> no tuned; err=1 after LOCK_TO (macro off).
- DDS_TUNE_RETRY_EN defined, locked never asserts -> 2 pll_reset pulses of 8 cycles each, then err=1.
- Drop locked in IDLE while tuned=1 -> tuned=0 next cycle. Assert reset mid-WAIT_IDLE -> all outputs at reset values, including counter_data=104.
